// File: rtl/traffic_corridor_ctrl_pkg.sv
// Shared types and helpers for the corridor controller: phase encoding,
// lamp decode and timer sizing.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GRN    = 3'd0,
        NS_YLW    = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GRN    = 3'd3,
        EW_YLW    = 3'd4,
        ALL_RED_B = 3'd5
    } phase_e;

    typedef struct packed {
        logic red_n;
        logic ylw_n;
        logic grn_n;
        logic red_w;
        logic ylw_w;
        logic grn_w;
    } lamps_t;

    // Exactly one lamp per approach is lit in every phase.
    function automatic lamps_t decode_lamps(input phase_e ph);
        lamps_t l;
        l = '0;
        case (ph)
            NS_GRN: begin
                l.grn_n = 1'b1;
                l.red_w = 1'b1;
            end
            NS_YLW: begin
                l.ylw_n = 1'b1;
                l.red_w = 1'b1;
            end
            EW_GRN: begin
                l.red_n = 1'b1;
                l.grn_w = 1'b1;
            end
            EW_YLW: begin
                l.red_n = 1'b1;
                l.ylw_w = 1'b1;
            end
            default: begin
                l.red_n = 1'b1;
                l.red_w = 1'b1;
            end
        endcase
        return l;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        case (ph)
            NS_GRN:    nxt = NS_YLW;
            NS_YLW:    nxt = ALL_RED_A;
            ALL_RED_A: nxt = EW_GRN;
            EW_GRN:    nxt = EW_YLW;
            EW_YLW:    nxt = ALL_RED_B;
            default:   nxt = NS_GRN;
        endcase
        return nxt;
    endfunction

    // The longest value a phase timer ever holds is either a green or the
    // staggered start-up all-red of the last intersection.
    function automatic int unsigned timer_width(input int unsigned grn_s,
                                                input int unsigned ylw_s,
                                                input int unsigned all_red_s,
                                                input int unsigned n_int,
                                                input int unsigned offset_s);
        int unsigned longest;
        longest = grn_s;
        if (ylw_s > longest) begin
            longest = ylw_s;
        end
        if (all_red_s + (n_int - 1) * offset_s > longest) begin
            longest = all_red_s + (n_int - 1) * offset_s;
        end
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/traffic_corridor_ctrl_if.sv
// Crosswalk request inputs and lamp outputs of the corridor controller.
interface traffic_corridor_ctrl_if #(
    parameter int unsigned N_INT = 2
) ();

    logic [N_INT-1:0] nrth_xwalk;
    logic [N_INT-1:0] west_xwalk;
    logic [N_INT-1:0] red_nrth;
    logic [N_INT-1:0] ylw_nrth;
    logic [N_INT-1:0] grn_nrth;
    logic [N_INT-1:0] red_west;
    logic [N_INT-1:0] ylw_west;
    logic [N_INT-1:0] grn_west;
    logic [N_INT-1:0] walk_nrth;
    logic [N_INT-1:0] stop_nrth;
    logic [N_INT-1:0] walk_west;
    logic [N_INT-1:0] stop_west;
    logic             tick_1hz;

    modport master (
        input  nrth_xwalk, west_xwalk,
        output red_nrth, ylw_nrth, grn_nrth,
        output red_west, ylw_west, grn_west,
        output walk_nrth, stop_nrth, walk_west, stop_west,
        output tick_1hz
    );

    modport slave (
        output nrth_xwalk, west_xwalk,
        input  red_nrth, ylw_nrth, grn_nrth,
        input  red_west, ylw_west, grn_west,
        input  walk_nrth, stop_nrth, walk_west, stop_west,
        input  tick_1hz
    );

endinterface

// File: rtl/traffic_corridor_ctrl_phase_fsm.sv
// One intersection: phase sequencer with tick timer, crosswalk request
// latches, walk interval and early termination of the opposing green.
module intersection_phase_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned IDX       = 0,
    parameter int unsigned GRN_S     = 10,
    parameter int unsigned MIN_GRN_S = 4,
    parameter int unsigned YLW_S     = 3,
    parameter int unsigned ALL_RED_S = 1,
    parameter int unsigned WALK_S    = 7,
    parameter int unsigned OFFSET_S  = 2,
    parameter int unsigned TW        = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   tick_i,
    input  logic   nrth_xwalk_i,
    input  logic   west_xwalk_i,
    output phase_e phase_o,
    output logic   walk_n_o,
    output logic   walk_w_o
);

    localparam logic [TW-1:0] START_T = TW'(ALL_RED_S + IDX * OFFSET_S);
    localparam logic [TW-1:0] EARLY_T = TW'(GRN_S - MIN_GRN_S + 1);
    localparam logic [TW-1:0] WALK_T  = TW'(WALK_S);
    localparam logic [TW-1:0] ONE_T   = TW'(1);

    phase_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] walk_cnt_q, walk_cnt_d;
    logic          req_n_q, req_n_d;
    logic          req_w_q, req_w_d;
    logic          walk_n_q, walk_n_d;
    logic          walk_w_q, walk_w_d;
    logic          nrth_prev_q, west_prev_q;
    logic          n_rise, w_rise;
    logic          clr_n, clr_w;
    logic          early;

    function automatic logic [TW-1:0] phase_dur(input phase_e ph);
        logic [TW-1:0] d;
        case (ph)
            NS_GRN, EW_GRN: d = TW'(GRN_S);
            NS_YLW, EW_YLW: d = TW'(YLW_S);
            default:        d = TW'(ALL_RED_S);
        endcase
        return d;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ALL_RED_B;
            timer_q     <= START_T;
            walk_cnt_q  <= '0;
            req_n_q     <= 1'b0;
            req_w_q     <= 1'b0;
            walk_n_q    <= 1'b0;
            walk_w_q    <= 1'b0;
            nrth_prev_q <= 1'b0;
            west_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            walk_cnt_q  <= walk_cnt_d;
            req_n_q     <= req_n_d;
            req_w_q     <= req_w_d;
            walk_n_q    <= walk_n_d;
            walk_w_q    <= walk_w_d;
            nrth_prev_q <= nrth_xwalk_i;
            west_prev_q <= west_xwalk_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        walk_cnt_d = walk_cnt_q;
        walk_n_d   = walk_n_q;
        walk_w_d   = walk_w_q;
        clr_n      = 1'b0;
        clr_w      = 1'b0;
        n_rise     = nrth_xwalk_i & ~nrth_prev_q;
        w_rise     = west_xwalk_i & ~west_prev_q;

        // A waiting cross request cuts the green short, but never while this
        // green's own walk is still lit and never before the minimum green.
        early = tick_i && (timer_q <= EARLY_T) &&
                ((state_q == NS_GRN && req_w_q && !walk_n_q) ||
                 (state_q == EW_GRN && req_n_q && !walk_w_q));

        if (tick_i) begin
            if (walk_n_q || walk_w_q) begin
                walk_cnt_d = walk_cnt_q - ONE_T;
                if (walk_cnt_q == ONE_T) begin
                    walk_n_d = 1'b0;
                    walk_w_d = 1'b0;
                end
            end
            if (timer_q == ONE_T || early) begin
                state_d = next_phase(state_q);
                timer_d = phase_dur(state_d);
                if (state_d == NS_GRN && req_n_q) begin
                    walk_n_d   = 1'b1;
                    walk_cnt_d = WALK_T;
                    clr_n      = 1'b1;
                end
                if (state_d == EW_GRN && req_w_q) begin
                    walk_w_d   = 1'b1;
                    walk_cnt_d = WALK_T;
                    clr_w      = 1'b1;
                end
            end else begin
                timer_d = timer_q - ONE_T;
            end
        end

        // A fresh press on the clearing cycle survives for the next green.
        req_n_d = (req_n_q & ~clr_n) | n_rise;
        req_w_d = (req_w_q & ~clr_w) | w_rise;
    end

    assign phase_o  = state_q;
    assign walk_n_o = walk_n_q;
    assign walk_w_o = walk_w_q;

endmodule

// File: rtl/traffic_corridor_ctrl.sv
// Corridor of N_INT intersections sharing one tick prescaler; start-up is
// staggered per intersection index to form a green wave.
module traffic_corridor_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned N_INT     = 2,
    parameter int unsigned CLK_DIV   = 50_000_000,
    parameter int unsigned GRN_S     = 10,
    parameter int unsigned MIN_GRN_S = 4,
    parameter int unsigned YLW_S     = 3,
    parameter int unsigned ALL_RED_S = 1,
    parameter int unsigned WALK_S    = 7,
    parameter int unsigned OFFSET_S  = 2
) (
    input  logic                   clk_50_mhz,
    input  logic                   reset,
    traffic_corridor_ctrl_if.master bus
);

    localparam int unsigned   TW        = timer_width(GRN_S, YLW_S, ALL_RED_S, N_INT, OFFSET_S);
    localparam int unsigned   PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    phase_e           phase_w [N_INT];
    lamps_t           lamps_w [N_INT];
    logic [N_INT-1:0] walk_n_w, walk_w_w;
    logic [N_INT-1:0] red_n, ylw_n, grn_n, red_w, ylw_w, grn_w;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_INT; gi++) begin : g_int
            intersection_phase_fsm #(
                .IDX      (gi),
                .GRN_S    (GRN_S),
                .MIN_GRN_S(MIN_GRN_S),
                .YLW_S    (YLW_S),
                .ALL_RED_S(ALL_RED_S),
                .WALK_S   (WALK_S),
                .OFFSET_S (OFFSET_S),
                .TW       (TW)
            ) u_fsm (
                .clk_i       (clk_50_mhz),
                .rst_i       (reset),
                .tick_i      (tick),
                .nrth_xwalk_i(bus.nrth_xwalk[gi]),
                .west_xwalk_i(bus.west_xwalk[gi]),
                .phase_o     (phase_w[gi]),
                .walk_n_o    (walk_n_w[gi]),
                .walk_w_o    (walk_w_w[gi])
            );

            assign lamps_w[gi] = decode_lamps(phase_w[gi]);
        end
    endgenerate

    always_comb begin
        red_n = '0;
        ylw_n = '0;
        grn_n = '0;
        red_w = '0;
        ylw_w = '0;
        grn_w = '0;
        for (int i = 0; i < N_INT; i++) begin
            red_n[i] = lamps_w[i].red_n;
            ylw_n[i] = lamps_w[i].ylw_n;
            grn_n[i] = lamps_w[i].grn_n;
            red_w[i] = lamps_w[i].red_w;
            ylw_w[i] = lamps_w[i].ylw_w;
            grn_w[i] = lamps_w[i].grn_w;
        end
    end

    assign bus.red_nrth  = red_n;
    assign bus.ylw_nrth  = ylw_n;
    assign bus.grn_nrth  = grn_n;
    assign bus.red_west  = red_w;
    assign bus.ylw_west  = ylw_w;
    assign bus.grn_west  = grn_w;
    assign bus.walk_nrth = walk_n_w;
    assign bus.stop_nrth = ~walk_n_w;
    assign bus.walk_west = walk_w_w;
    assign bus.stop_west = ~walk_w_w;
    assign bus.tick_1hz  = tick;

endmodule
